mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline. It owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over multiple cycles. It drives MDUReadyE low while an operation is in flight; the hazard logic stalls IF/ID/EX on ~MDUReadyE. It also services MTHI/MTLO and exposes HI/LO for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and HI/LO width; the datapath is specified for 32 only.
CNT_W, 5, iteration counter width; 2^CNT_W equals WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
MDUOpE  input  3  EX-stage op: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
SrcAE  input  32  rs operand, after EX forwarding
SrcBE  input  32  rt operand, after EX forwarding
MDUReadyE  output  1  1 = the EX instruction may advance; 0 = stall EX and earlier stages
HiE  output  32  current HI register (MFHI data)
LoE  output  32  current LO register (MFLO data)
BusyE  output  1  registered; 1 while in CALC state (debug/perf)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, HI=0, LO=0, counter=0, BusyE=0. MDUReadyE=1 once rst deasserts. Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, CALC, DONE.
- IDLE:
  - MDUOpE in {MULT, MULTU, DIV, DIVU}: MDUReadyE=0 combinationally in the same cycle. At the edge, latch operand magnitudes, sign flags and the op, clear the counter, and go to CALC.
  - MDUOpE=MTHI: HI<=SrcAE at the edge. MDUReadyE stays 1. State stays IDLE.
  - MDUOpE=MTLO: LO<=SrcAE at the edge. MDUReadyE stays 1. State stays IDLE.
  - Any other op: no state change, MDUReadyE=1.
- CALC: MDUReadyE=0, BusyE=1. Runs exactly 32 iterations, one bit per cycle, with the counter going 0..31.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division producing 32 quotient bits and the remainder.
  - MDUOpE, SrcAE and SrcBE are ignored during CALC; the latched copies are used.
  - On the edge ending iteration 31: write HI/LO, go to DONE.
- DONE: MDUReadyE=1, lasting exactly one cycle, during which the stalled instruction leaves EX. MDUOpE is ignored in DONE. Next state is IDLE. A following mult/div instruction is seen in IDLE one cycle later.
- Timing: start sampled in cycle T. MDUReadyE is low in cycles T..T+32 (33 cycles) and high in T+33. The new HI/LO values are visible on HiE/LoE from T+33.
- Signed rules:
  - MULT: multiply |A|*|B|, then negate the 64-bit product if the signs differ. HI = product[63:32], LO = product[31:0].
  - DIV: divide magnitudes. Negate the quotient if the signs differ. The remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- Unsigned rules: MULTU and DIVU use the operands unsigned. Results are modulo 2^64 for the product and exact for the quotient and remainder.
- Divide by zero (DIV or DIVU with SrcBE=0): the full 33-cycle latency still applies. Result is LO=0xFFFFFFFF and HI=SrcAE as latched (raw, not negated).
- HI/LO change only on: MT* in IDLE, completion at the end of CALC, and reset.
- HiE/LoE are direct register outputs. A read in the same cycle as an MTHI/MTLO write returns the old value; the pipeline separates MT*/MF* by at least one cycle.
- No flush input: an operation already started always completes.

Test Plan:
1. Reset, then MULT with SrcAE=0xFFFFFFFD (-3), SrcBE=5 -> MDUReadyE=0 for 33 cycles, then 1 for one cycle; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. MULTU with 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. DIVU 100/7 -> LO=14, HI=2.
3. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/-1 -> LO=0x80000000, HI=0. DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
4. Back-to-back: MULT held during stall, then DIV presented in the cycle after DONE -> the second op starts from IDLE and the first result is not overwritten early. Also change SrcAE during CALC -> result unaffected.
5. MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> MDUReadyE never drops; next cycle HiE=0x12345678, LoE=0x9ABCDEF0.
6. rst asserted at CALC iteration 10 -> next cycle state=IDLE, HI=LO=0, MDUReadyE=1, BusyE=0; a new MULT afterwards computes correctly.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit for the EX stage. It owns HI/LO and runs
// MULT/MULTU/DIV/DIVU at one bit per cycle. It also services MTHI/MTLO.
//
// Handshake: MDUReadyE=1 means the EX instruction may advance this cycle.
// MDUReadyE drops combinationally in the IDLE cycle where a mult/div op is
// presented. It stays low through all 32 CALC cycles. It returns high for the
// single DONE cycle, in which the stalled instruction leaves EX.
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       MDUOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             MDUReadyE,
  output logic [WIDTH-1:0] HiE,
  output logic [WIDTH-1:0] LoE,
  output logic             BusyE
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;       // {upper, lower} working register
  logic [WIDTH-1:0]     mag_b;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0]     raw_a;     // dividend as presented (divide-by-zero HI)
  logic                 is_div;
  logic                 neg_res;   // product / quotient needs negation
  logic                 neg_a;     // remainder takes the dividend sign
  logic                 div_zero;

  logic                 start;
  logic                 op_signed;
  logic [WIDTH-1:0]     mag_a_in, mag_b_in;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH+1:0]     div_diff;
  logic [WIDTH:0]       div_shift;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Decode the IDLE-cycle start condition and the operand magnitudes
  always_comb begin
    start     = (state == IDLE) &&
                (MDUOpE == OP_MULT || MDUOpE == OP_MULTU ||
                 MDUOpE == OP_DIV  || MDUOpE == OP_DIVU);
    op_signed = (MDUOpE == OP_MULT) || (MDUOpE == OP_DIV);
    mag_a_in  = (op_signed && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    mag_b_in  = (op_signed && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
  end

  // Next-state and ready logic
  always_comb begin
    state_nxt = state;
    MDUReadyE = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CALC;
          MDUReadyE = 1'b0;
        end
      end
      CALC: begin
        MDUReadyE = 1'b0;
        if (cnt == '1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and the registered busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      BusyE <= 1'b0;
    end else begin
      state <= state_nxt;
      BusyE <= (state_nxt == CALC);
    end
  end

  // One iteration step: a shift-add multiply or a restoring divide, sharing acc
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_b};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    if (is_div) begin
      if (!div_diff[WIDTH+1])
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {mul_sum, acc[WIDTH-1:1]};
      else
        acc_step = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step's result, and divide-by-zero override
  always_comb begin
    prod_fix = neg_res ? -acc_step : acc_step;
    if (!is_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = raw_a;
      res_lo = '1;
    end else begin
      res_hi = neg_a   ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
      res_lo = neg_res ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
    end
  end

  // Datapath: operand latch, iteration, HI/LO writes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mag_b    <= '0;
      raw_a    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_a    <= 1'b0;
      div_zero <= 1'b0;
      HiE      <= '0;
      LoE      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= '0;
            acc      <= {{WIDTH{1'b0}}, (MDUOpE == OP_MULT || MDUOpE == OP_MULTU) ? mag_b_in : mag_a_in};
            mag_b    <= (MDUOpE == OP_MULT || MDUOpE == OP_MULTU) ? mag_a_in : mag_b_in;
            raw_a    <= SrcAE;
            is_div   <= (MDUOpE == OP_DIV) || (MDUOpE == OP_DIVU);
            neg_res  <= op_signed && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            neg_a    <= op_signed && SrcAE[WIDTH-1];
            div_zero <= (SrcBE == '0);
          end else if (MDUOpE == OP_MTHI) begin
            HiE <= SrcAE;
          end else if (MDUOpE == OP_MTLO) begin
            LoE <= SrcAE;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            HiE <= res_hi;
            LoE <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Bench for mdu_iterative: directed and randomized ops against an arithmetic model of HI/LO.
module tb_mdu_iterative;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        ready;
  logic [31:0] hi, lo;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] m_hi, m_lo;   // model HI/LO

  mdu_iterative dut (
    .clk(clk), .rst(rst), .MDUOpE(op_i), .SrcAE(a_i), .SrcBE(b_i),
    .MDUReadyE(ready), .HiE(hi), .LoE(lo), .BusyE(busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the architectural rules
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    int sa, sb, q, r;
    longint p;
    logic [63:0] u;
    sa = a; sb = b;
    h = m_hi; l = m_lo;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); {h, l} = p; end
      3'd2: begin u = {32'd0, a} * {32'd0, b}; {h, l} = u; end
      3'd3: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = 32'h80000000; end
        else begin q = sa / sb; r = sa % sb; h = r; l = q; end
      end
      3'd4: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: ;
    endcase
  endfunction

  // Run one mult/div op from IDLE; op stays held through the stall (optionally scrambled)
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble);
    logic [31:0] eh, el;
    int low, busy_n;
    bit early;
    model(op, a, b, eh, el);
    @(negedge clk);
    op_i = op; a_i = a; b_i = b;
    #1;
    low = 0; busy_n = 0; early = 0;
    while (ready === 1'b0 && low < 100) begin
      low++;
      if (busy === 1'b1) busy_n++;
      if (hi !== m_hi || lo !== m_lo) early = 1;
      @(negedge clk);
      if (scramble) begin op_i = 3'($urandom_range(0, 7)); a_i = $urandom; b_i = $urandom; end
      #1;
    end
    if (busy === 1'b1) busy_n++;
    n_checks++;
    if (low !== 33) $display("FAIL stall_len op=%0d got=%0d want=33", op, low); else n_pass++;
    n_checks++;
    if (busy_n !== 32) $display("FAIL busy_len op=%0d got=%0d want=32", op, busy_n); else n_pass++;
    n_checks++;
    if (early !== 1'b0) $display("FAIL hilo_early op=%0d got=%0d want=0", op, early); else n_pass++;
    n_checks++;
    if (hi !== eh) $display("FAIL hi op=%0d a=%h b=%h got=%h want=%h", op, a, b, hi, eh); else n_pass++;
    n_checks++;
    if (lo !== el) $display("FAIL lo op=%0d a=%h b=%h got=%h want=%h", op, a, b, lo, el); else n_pass++;
    m_hi = eh; m_lo = el;
  endtask

  task automatic go_idle();
    @(negedge clk);
    op_i = 3'd0; a_i = $urandom; b_i = $urandom;
    #1;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL idle_after_done got=%b%b want=10", ready, busy);
    else n_pass++;
  endtask

  task automatic check_hilo(input logic [31:0] h, input logic [31:0] l, input string name);
    n_checks++;
    if (hi !== h || lo !== l) $display("FAIL %s got=%h_%h want=%h_%h", name, hi, lo, h, l);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; op_i = 3'd0; a_i = 0; b_i = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    m_hi = 0; m_lo = 0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || hi !== 0 || lo !== 0)
      $display("FAIL reset got=%b%b_%h_%h want=10_0_0", ready, busy, hi, lo);
    else n_pass++;
  endtask

  task automatic test_mult();
    do_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0);
    check_hilo(32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5");
    go_idle();
    for (int i = 0; i < 4; i++) begin
      do_op(3'd1, $urandom, $urandom, 1'b0);
      go_idle();
    end
  endtask

  task automatic test_multu_divu();
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check_hilo(32'hFFFFFFFE, 32'h00000001, "multu_max");
    go_idle();
    do_op(3'd4, 32'd100, 32'd7, 1'b0);
    check_hilo(32'd2, 32'd14, "divu_100_7");
    go_idle();
  endtask

  task automatic test_div();
    do_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    check_hilo(32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    go_idle();
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check_hilo(32'h0, 32'h80000000, "div_min_m1");
    go_idle();
    do_op(3'd4, 32'd5, 32'd0, 1'b0);
    check_hilo(32'd5, 32'hFFFFFFFF, "divu_by_zero");
    go_idle();
    do_op(3'd3, 32'hFFFFFF00, 32'd0, 1'b0);
    check_hilo(32'hFFFFFF00, 32'hFFFFFFFF, "div_neg_by_zero");
    go_idle();
  endtask

  task automatic test_back_to_back();
    do_op(3'd1, $urandom, $urandom, 1'b1);
    do_op(3'd3, $urandom, 32'($urandom_range(1, 1000)), 1'b1);
    do_op(3'd2, $urandom, $urandom, 1'b0);
    go_idle();
  endtask

  task automatic test_mt();
    @(negedge clk);
    op_i = 3'd5; a_i = 32'h12345678;
    #1;
    n_checks++;
    if (ready !== 1'b1 || hi !== m_hi) $display("FAIL mthi_same_cycle got=%b_%h want=1_%h", ready, hi, m_hi);
    else n_pass++;
    @(negedge clk);
    op_i = 3'd6; a_i = 32'h9ABCDEF0;
    #1;
    n_checks++;
    if (ready !== 1'b1 || hi !== 32'h12345678 || lo !== m_lo)
      $display("FAIL mthi_write got=%b_%h_%h want=1_12345678_%h", ready, hi, lo, m_lo);
    else n_pass++;
    @(negedge clk);
    op_i = 3'd0;
    #1;
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    check_hilo(32'h12345678, 32'h9ABCDEF0, "mtlo_write");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    op_i = 3'd1; a_i = 32'd1234; b_i = 32'd5678;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op_i = 3'd0;
    #1;
    m_hi = 0; m_lo = 0;
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || hi !== 0 || lo !== 0)
      $display("FAIL reset_mid got=%b%b_%h_%h want=10_0_0", ready, busy, hi, lo);
    else n_pass++;
    do_op(3'd1, 32'hFFFFFFF0, 32'd3, 1'b0);
    go_idle();
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(1, 4));
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do_op(op, $urandom, b, 1'b1);
    end
    go_idle();
  endtask

  // Test sequence and summary
  initial begin
    test_reset();
    test_mult();
    test_multu_divu();
    test_div();
    test_back_to_back();
    test_mt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
